// File: rtl/vga_pkg.sv
// Shared VGA timing constants and arbiter state encoding for the framebuffer arbiter slice.
package vga_pkg;

    localparam int H_ACTIVE       = 640;
    localparam int H_TOTAL        = 800;
    localparam int V_ACTIVE       = 480;
    localparam int V_TOTAL        = 525;
    localparam int WORDS_PER_LINE = 40;
    localparam int FB_WORDS       = 19200;

    typedef enum logic {
        IDLE     = 1'b0,
        CPU_WAIT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/vga_fetch_addr.sv
// Combinational display-fetch slot detector: decides whether this pixel clock belongs to the
// display, and which framebuffer word the display needs next.
module vga_fetch_addr #(
    parameter int H_TOTAL        = 800,
    parameter int V_ACTIVE       = 480,
    parameter int V_TOTAL        = 525,
    parameter int WORDS_PER_LINE = 40
) (
    input  logic [9:0]  counter_x,
    input  logic [9:0]  counter_y,
    output logic        slot_valid,
    output logic [14:0] slot_addr
);
    import vga_pkg::*;

    logic        mid_slot;
    logic        wrap_slot;
    logic [9:0]  line;
    logic [5:0]  group;
    logic [14:0] line_ext;

    // Mid-line slots prefetch the next 16-pixel group; the slot near end of line prefetches
    // group 0 of the following line (wrapping from the last frame line back to line 0).
    always_comb begin
        mid_slot  = (counter_x[3:0] == 4'd8) &&
                    (counter_x < 10'((WORDS_PER_LINE - 1) * 16 + 8));
        wrap_slot = (counter_x == 10'(H_TOTAL - 8));
        line      = counter_y;
        group     = counter_x[9:4] + 6'd1;
        if (wrap_slot) begin
            group = '0;
            line  = (counter_y == 10'(V_TOTAL - 1)) ? '0 : counter_y + 10'd1;
        end
        slot_valid = (mid_slot || wrap_slot) && (line < 10'(V_ACTIVE));
        line_ext   = {5'd0, line};
        slot_addr  = (line_ext << 5) + (line_ext << 3) + {9'd0, group};
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display prefetch slots always win, CPU accesses fill the
// remaining cycles, and the fetched words are shifted out as a registered 1-bpp pixel stream.
module vga_fb_arbiter #(
    parameter int H_ACTIVE       = 640,
    parameter int H_TOTAL        = 800,
    parameter int V_ACTIVE       = 480,
    parameter int V_TOTAL        = 525,
    parameter int WORDS_PER_LINE = 40,
    parameter int FB_WORDS       = 19200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  counter_x,
    input  logic [9:0]  counter_y,
    output logic [14:0] mem_addr,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [14:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic [15:0] cpu_rdata,
    output logic        pixel_out
);
    import vga_pkg::*;

    arb_state_t  state;
    arb_state_t  state_next;
    logic        slot_valid;
    logic [14:0] slot_addr;
    logic        disp_issue;
    logic        cpu_issue;
    logic        cpu_reject;
    logic        addr_ok;
    logic        visible;
    logic        wait_we;
    logic        wait_err;
    logic        disp_pending;
    logic [14:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] next_word;
    logic [15:0] cur_word;

    vga_fetch_addr #(
        .H_TOTAL        (H_TOTAL),
        .V_ACTIVE       (V_ACTIVE),
        .V_TOTAL        (V_TOTAL),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_fetch (
        .counter_x  (counter_x),
        .counter_y  (counter_y),
        .slot_valid (slot_valid),
        .slot_addr  (slot_addr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Issues are gated by reset so the combinational memory port reads all-zero while in reset;
    // out-of-range requests still take the CPU_WAIT turn so they get an error ack.
    always_comb begin
        state_next = state;
        disp_issue = slot_valid && !reset;
        cpu_issue  = 1'b0;
        cpu_reject = 1'b0;
        addr_ok    = (cpu_addr < 15'(FB_WORDS));
        visible    = (counter_x < 10'(H_ACTIVE)) && (counter_y < 10'(V_ACTIVE));
        if (state == IDLE) begin
            if (cpu_req && !slot_valid && !reset) begin
                cpu_issue  = addr_ok;
                cpu_reject = !addr_ok;
                state_next = CPU_WAIT;
            end
        end else begin
            state_next = IDLE;
        end

        mem_addr  = addr_q;
        mem_we    = 1'b0;
        mem_wdata = wdata_q;
        if (disp_issue) begin
            mem_addr = slot_addr;
        end else if (cpu_issue) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_wdata = cpu_wdata;
        end

        cpu_ack   = (state == CPU_WAIT);
        cpu_err   = cpu_ack && wait_err;
        cpu_rdata = (cpu_ack && !wait_we && !wait_err) ? mem_rdata : '0;
    end

    // Display words flow mem_rdata -> next_word -> cur_word, the latter swapping at each
    // 16-pixel boundary so the pixel mux always sees the word for the current group.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_we      <= 1'b0;
            wait_err     <= 1'b0;
            disp_pending <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            next_word    <= '0;
            cur_word     <= '0;
            pixel_out    <= 1'b0;
        end else begin
            if (cpu_issue || cpu_reject) begin
                wait_we  <= cpu_we;
                wait_err <= cpu_reject;
            end
            disp_pending <= disp_issue;
            addr_q       <= mem_addr;
            wdata_q      <= mem_wdata;
            if (disp_pending) begin
                next_word <= mem_rdata;
            end
            if (counter_x[3:0] == 4'd15) begin
                cur_word <= next_word;
            end
            pixel_out <= visible & cur_word[4'd15 - counter_x[3:0]];
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: scenario tasks plus randomized CPU traffic checked
// against a shadow framebuffer and an arithmetic model of the display fetch schedule.
module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  counter_x;
    logic [9:0]  counter_y;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [14:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic        cpu_err;
    logic [15:0] cpu_rdata;
    logic        pixel_out;

    logic [15:0] mem    [0:32767];
    logic [15:0] shadow [0:32767];
    int tests_run = 0;
    int tests_failed = 0;
    int cx;
    int cy;

    vga_fb_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .counter_x (counter_x),
        .counter_y (counter_y),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_err   (cpu_err),
        .cpu_rdata (cpu_rdata),
        .pixel_out (pixel_out)
    );

    always #5 clk = ~clk;

    // Synchronous-read framebuffer RAM: read data appears the cycle after the address.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    // Display fetch schedule: word line*40+group, or -1 when the cycle is not a fetch slot.
    function automatic int exp_slot(input int x, input int y);
        int line;
        int group;
        if (x % 16 == 8 && x < 632) begin
            line  = y;
            group = x / 16 + 1;
        end else if (x == 792) begin
            line  = (y == 524) ? 0 : y + 1;
            group = 0;
        end else begin
            return -1;
        end
        if (line >= 480) return -1;
        return line * 40 + group;
    endfunction

    task automatic drive_pos();
        counter_x = 10'(cx);
        counter_y = 10'(cy);
    endtask

    task automatic goto_pos(input int x, input int y);
        @(posedge clk);
        #1;
        cx = x;
        cy = y;
        drive_pos();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (cx == 799) begin
            cx = 0;
            cy = (cy == 524) ? 0 : cy + 1;
        end else begin
            cx = cx + 1;
        end
        drive_pos();
    endtask

    task automatic test_reset();
        cx = 8;
        cy = 0;
        drive_pos();
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 15'd3;
        cpu_wdata = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run += 7;
            if (cpu_ack !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_ack: actual %0h required 0", cpu_ack); end
            if (cpu_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_err: actual %0h required 0", cpu_err); end
            if (cpu_rdata !== 16'h0) begin tests_failed++; $display("[TB] FAIL rst_rdata: actual %0h required 0", cpu_rdata); end
            if (mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_we: actual %0h required 0", mem_we); end
            if (mem_addr !== 15'h0) begin tests_failed++; $display("[TB] FAIL rst_addr: actual %0h required 0", mem_addr); end
            if (mem_wdata !== 16'h0) begin tests_failed++; $display("[TB] FAIL rst_wdata: actual %0h required 0", mem_wdata); end
            if (pixel_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_pixel: actual %0h required 0", pixel_out); end
        end
        @(posedge clk);
        #1;
        reset   = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        tests_run += 2;
        if (mem_addr !== 15'd1) begin tests_failed++; $display("[TB] FAIL rst_release_slot: actual %0d required 1", mem_addr); end
        if (cpu_ack !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_release_ack: actual %0h required 0", cpu_ack); end
    endtask

    task automatic test_line0_fetch();
        int e;
        int last;
        last = -1;
        goto_pos(0, 0);
        for (int i = 0; i < 800; i++) begin
            if (i > 0) step();
            @(negedge clk);
            e = exp_slot(cx, cy);
            tests_run++;
            if (e >= 0) begin
                if (mem_addr !== 15'(e) || mem_we !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL slot_addr x=%0d y=%0d: actual %0d we=%0h required %0d we=0", cx, cy, mem_addr, mem_we, e);
                end
                last = e;
            end else if (mem_we !== 1'b0 || (last >= 0 && mem_addr !== 15'(last))) begin
                tests_failed++;
                $display("[TB] FAIL idle_hold x=%0d: actual addr %0d we=%0h required addr %0d we=0", cx, mem_addr, mem_we, last);
            end
            if (cx == 8 || cx == 24 || cx == 616) begin
                tests_run++;
                e = (cx == 8) ? 1 : (cx == 24) ? 2 : 39;
                if (mem_addr !== 15'(e)) begin
                    tests_failed++;
                    $display("[TB] FAIL line0_x%0d: actual %0d required %0d", cx, mem_addr, e);
                end
            end
        end
    endtask

    task automatic test_frame_wrap();
        goto_pos(600, 479);
        while (cx != 792) begin
            step();
            @(negedge clk);
            if (cx == 791) begin
                tests_run++;
                if (mem_addr !== 15'd19199) begin tests_failed++; $display("[TB] FAIL wrap_hold479: actual %0d required 19199", mem_addr); end
            end
        end
        tests_run += 2;
        if (mem_addr !== 15'd19199) begin tests_failed++; $display("[TB] FAIL wrap_y479_addr: actual %0d required 19199", mem_addr); end
        if (mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL wrap_y479_we: actual %0h required 0", mem_we); end
        goto_pos(790, 524);
        step();
        step();
        @(negedge clk);
        tests_run += 2;
        if (mem_addr !== 15'd0) begin tests_failed++; $display("[TB] FAIL wrap_y524_addr: actual %0d required 0", mem_addr); end
        if (mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL wrap_y524_we: actual %0h required 0", mem_we); end
    endtask

    task automatic test_collision();
        logic [15:0] w;
        logic [15:0] d;
        int px;
        w = 16'($urandom) | 16'h0100;
        d = 16'($urandom);
        mem[401] = w;
        shadow[401] = w;
        goto_pos(6, 10);
        step();
        step();
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 15'd100;
        cpu_wdata = d;
        @(negedge clk);
        tests_run += 3;
        if (mem_addr !== 15'd401) begin tests_failed++; $display("[TB] FAIL coll_x8_addr: actual %0d required 401", mem_addr); end
        if (mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL coll_x8_we: actual %0h required 0", mem_we); end
        if (cpu_ack !== 1'b0) begin tests_failed++; $display("[TB] FAIL coll_x8_ack: actual %0h required 0", cpu_ack); end
        step();
        @(negedge clk);
        tests_run += 4;
        if (mem_addr !== 15'd100) begin tests_failed++; $display("[TB] FAIL coll_x9_addr: actual %0d required 100", mem_addr); end
        if (mem_we !== 1'b1) begin tests_failed++; $display("[TB] FAIL coll_x9_we: actual %0h required 1", mem_we); end
        if (mem_wdata !== d) begin tests_failed++; $display("[TB] FAIL coll_x9_wdata: actual %0h required %0h", mem_wdata, d); end
        if (cpu_ack !== 1'b0) begin tests_failed++; $display("[TB] FAIL coll_x9_ack: actual %0h required 0", cpu_ack); end
        step();
        @(negedge clk);
        tests_run += 3;
        if (cpu_ack !== 1'b1) begin tests_failed++; $display("[TB] FAIL coll_x10_ack: actual %0h required 1", cpu_ack); end
        if (cpu_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL coll_x10_err: actual %0h required 0", cpu_err); end
        if (mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL coll_x10_we: actual %0h required 0", mem_we); end
        step();
        cpu_req = 1'b0;
        shadow[100] = d;
        tests_run++;
        if (mem[100] !== d) begin tests_failed++; $display("[TB] FAIL coll_mem100: actual %0h required %0h", mem[100], d); end
        while (cx < 32) begin
            step();
            @(negedge clk);
            px = cx - 1;
            if (px >= 16) begin
                tests_run++;
                if (pixel_out !== w[15 - (px % 16)]) begin
                    tests_failed++;
                    $display("[TB] FAIL coll_pixel x=%0d: actual %0h required %0h", px, pixel_out, w[15 - (px % 16)]);
                end
            end
        end
    endtask

    task automatic test_cpu_read_vblank();
        mem[5] = 16'hA5A5;
        shadow[5] = 16'hA5A5;
        goto_pos(100, 490);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 15'd5;
        @(negedge clk);
        tests_run += 3;
        if (mem_addr !== 15'd5) begin tests_failed++; $display("[TB] FAIL rd_issue_addr: actual %0d required 5", mem_addr); end
        if (mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL rd_issue_we: actual %0h required 0", mem_we); end
        if (cpu_ack !== 1'b0) begin tests_failed++; $display("[TB] FAIL rd_issue_ack: actual %0h required 0", cpu_ack); end
        step();
        @(negedge clk);
        tests_run += 3;
        if (cpu_ack !== 1'b1) begin tests_failed++; $display("[TB] FAIL rd_ack: actual %0h required 1", cpu_ack); end
        if (cpu_rdata !== 16'hA5A5) begin tests_failed++; $display("[TB] FAIL rd_data: actual %0h required a5a5", cpu_rdata); end
        if (cpu_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL rd_err: actual %0h required 0", cpu_err); end
        step();
        cpu_req = 1'b0;
        @(negedge clk);
        tests_run++;
        if (cpu_ack !== 1'b0) begin tests_failed++; $display("[TB] FAIL rd_ack_drop: actual %0h required 0", cpu_ack); end
    endtask

    task automatic test_out_of_range();
        mem[19200] = 16'h1234;
        step();
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 15'd19200;
        cpu_wdata = 16'hFFFF;
        @(negedge clk);
        tests_run += 3;
        if (mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL oor_issue_we: actual %0h required 0", mem_we); end
        if (mem_addr !== 15'd5) begin tests_failed++; $display("[TB] FAIL oor_hold_addr: actual %0d required 5", mem_addr); end
        if (cpu_ack !== 1'b0) begin tests_failed++; $display("[TB] FAIL oor_early_ack: actual %0h required 0", cpu_ack); end
        step();
        @(negedge clk);
        tests_run += 3;
        if (cpu_ack !== 1'b1) begin tests_failed++; $display("[TB] FAIL oor_ack: actual %0h required 1", cpu_ack); end
        if (cpu_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL oor_err: actual %0h required 1", cpu_err); end
        if (mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL oor_wait_we: actual %0h required 0", mem_we); end
        step();
        cpu_req = 1'b0;
        @(negedge clk);
        tests_run += 3;
        if (cpu_ack !== 1'b0) begin tests_failed++; $display("[TB] FAIL oor_ack_drop: actual %0h required 0", cpu_ack); end
        if (cpu_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL oor_err_drop: actual %0h required 0", cpu_err); end
        if (mem[19200] !== 16'h1234) begin tests_failed++; $display("[TB] FAIL oor_mem: actual %0h required 1234", mem[19200]); end
    endtask

    task automatic test_pixels();
        int px;
        int py;
        logic [15:0] wv;
        logic expb;
        for (int a = 0; a < 80; a++) begin
            wv = 16'($urandom);
            mem[a] = wv;
            shadow[a] = wv;
        end
        mem[0] = 16'h8001;
        shadow[0] = 16'h8001;
        goto_pos(780, 524);
        for (int i = 0; i < 40 && !(cx == 0 && cy == 0); i++) step();
        for (int i = 0; i < 1600; i++) begin
            px = cx;
            py = cy;
            step();
            @(negedge clk);
            wv = shadow[py * 40 + px / 16];
            expb = (px < 640 && py < 480) ? wv[15 - (px % 16)] : 1'b0;
            tests_run++;
            if (pixel_out !== expb) begin
                tests_failed++;
                $display("[TB] FAIL pixel x=%0d y=%0d: actual %0h required %0h", px, py, pixel_out, expb);
            end
        end
    endtask

    task automatic test_reset_midtxn();
        logic [15:0] w6;
        w6 = 16'($urandom);
        mem[6] = w6;
        shadow[6] = w6;
        goto_pos(200, 500);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 15'd5;
        @(negedge clk);
        step();
        reset = 1'b1;
        @(negedge clk);
        tests_run += 7;
        if (cpu_ack !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_rst_ack: actual %0h required 0", cpu_ack); end
        if (cpu_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_rst_err: actual %0h required 0", cpu_err); end
        if (cpu_rdata !== 16'h0) begin tests_failed++; $display("[TB] FAIL mid_rst_rdata: actual %0h required 0", cpu_rdata); end
        if (mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_rst_we: actual %0h required 0", mem_we); end
        if (mem_addr !== 15'h0) begin tests_failed++; $display("[TB] FAIL mid_rst_addr: actual %0h required 0", mem_addr); end
        if (mem_wdata !== 16'h0) begin tests_failed++; $display("[TB] FAIL mid_rst_wdata: actual %0h required 0", mem_wdata); end
        if (pixel_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_rst_pixel: actual %0h required 0", pixel_out); end
        step();
        cpu_req = 1'b0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests_run++;
            if (cpu_ack !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_rst_no_ack: actual %0h required 0", cpu_ack); end
            step();
        end
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 15'd6;
        @(negedge clk);
        tests_run++;
        if (mem_addr !== 15'd6) begin tests_failed++; $display("[TB] FAIL mid_rst_reissue_addr: actual %0d required 6", mem_addr); end
        step();
        @(negedge clk);
        tests_run += 2;
        if (cpu_ack !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_rst_reissue_ack: actual %0h required 1", cpu_ack); end
        if (cpu_rdata !== w6) begin tests_failed++; $display("[TB] FAIL mid_rst_reissue_data: actual %0h required %0h", cpu_rdata, w6); end
        step();
        cpu_req = 1'b0;
    endtask

    task automatic test_random_traffic();
        int e;
        int issue_k;
        int ack_k;
        int addr;
        int gap;
        logic we;
        logic err;
        logic [15:0] wd;
        logic [15:0] exp_rd;
        goto_pos(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)));
        for (int t = 0; t < 150; t++) begin
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                tests_run++;
                if (cpu_ack !== 1'b0) begin tests_failed++; $display("[TB] FAIL rnd_gap_ack: actual %0h required 0", cpu_ack); end
                step();
            end
            we  = 1'($urandom_range(0, 1));
            wd  = 16'($urandom);
            err = ($urandom_range(0, 9) == 0) && (exp_slot(cx, cy) < 0);
            addr = err ? int'($urandom_range(19200, 32767)) : int'($urandom_range(0, 19199));
            exp_rd = (we || err) ? 16'h0 : shadow[addr];
            issue_k = (exp_slot(cx, cy) >= 0) ? 1 : 0;
            ack_k = issue_k + 1;
            cpu_req   = 1'b1;
            cpu_we    = we;
            cpu_addr  = 15'(addr);
            cpu_wdata = wd;
            for (int k = 0; k <= ack_k; k++) begin
                if (k > 0) step();
                @(negedge clk);
                e = exp_slot(cx, cy);
                tests_run++;
                if (e >= 0) begin
                    if (mem_addr !== 15'(e) || mem_we !== 1'b0) begin
                        tests_failed++;
                        $display("[TB] FAIL rnd_slot x=%0d y=%0d: actual %0d we=%0h required %0d we=0", cx, cy, mem_addr, mem_we, e);
                    end
                end else if (k == issue_k && !err) begin
                    if (mem_addr !== 15'(addr) || mem_we !== we || (we && mem_wdata !== wd)) begin
                        tests_failed++;
                        $display("[TB] FAIL rnd_issue t=%0d: actual %0d/%0h/%0h required %0d/%0h/%0h", t, mem_addr, mem_we, mem_wdata, addr, we, wd);
                    end
                end else if (mem_we !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL rnd_stray_we t=%0d k=%0d: actual %0h required 0", t, k, mem_we);
                end
                tests_run++;
                if (k < ack_k) begin
                    if (cpu_ack !== 1'b0) begin tests_failed++; $display("[TB] FAIL rnd_early_ack t=%0d k=%0d: actual %0h required 0", t, k, cpu_ack); end
                end else if (cpu_ack !== 1'b1 || cpu_err !== err || cpu_rdata !== exp_rd) begin
                    tests_failed++;
                    $display("[TB] FAIL rnd_ack t=%0d: actual ack=%0h err=%0h rd=%0h required ack=1 err=%0h rd=%0h", t, cpu_ack, cpu_err, cpu_rdata, err, exp_rd);
                end
            end
            if (we && !err) shadow[addr] = wd;
            step();
            cpu_req = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int a = 0; a < 32768; a++) begin
            mem[a] = 16'h0;
            shadow[a] = 16'h0;
        end
        cx = 0;
        cy = 0;
        drive_pos();
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        test_reset();
        test_line0_fetch();
        test_frame_wrap();
        test_collision();
        test_cpu_read_vblank();
        test_out_of_range();
        test_pixels();
        test_reset_midtxn();
        test_random_traffic();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
